// File: rtl/popcount_accumulator.sv
// Sums the compressed 3-bit lane counts of each beat and accumulates them over a
// programmed number of beats, returning one total through a valid/ready port.
//
// state | meaning
// IDLE  | waiting for start; no handshakes offered
// ACCUM | accepting beats, one per cycle, until the beat counter runs out
// DONE  | result held on out_sum/out_err until the consumer takes it
module popcount_accumulator #(
    parameter int LANES = 4,
    parameter int ACC_W = 16,
    parameter int LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3*LANES-1:0]   in_cnt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_sum,
    output logic                 out_err,
    output logic                 busy
);

    localparam int BEAT_W = $clog2(7*LANES+1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [LEN_W-1:0]    cnt;
    logic [BEAT_W-1:0]   beat_sum;
    logic                lane_bad;
    logic [ACC_W:0]      acc_wide;
    logic                sat;
    logic [ACC_W-1:0]    acc_next;

    // Illegal codes 6 and 7 still contribute their binary value to the sum.
    always_comb begin
        beat_sum = '0;
        lane_bad = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            beat_sum = beat_sum + BEAT_W'(in_cnt[3*i +: 3]);
            lane_bad = lane_bad | (in_cnt[3*i+1 +: 2] == 2'b11);
        end
    end

    always_comb begin
        acc_wide = {1'b0, out_sum} + (ACC_W+1)'(beat_sum);
        sat      = acc_wide[ACC_W];
        acc_next = sat ? '1 : acc_wide[ACC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            out_sum   <= '0;
            out_err   <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        out_sum <= '0;
                        out_err <= 1'b0;
                        busy    <= 1'b1;
                        if (len != '0) begin
                            cnt      <= len;
                            state    <= ACCUM;
                            in_ready <= 1'b1;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        out_sum <= acc_next;
                        if (sat || lane_bad)
                            out_err <= 1'b1;
                        cnt <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // start is deliberately ignored here, even on the handshake cycle
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_accumulator.sv
// Directed bench for popcount_accumulator: a job table for the 16-bit instance,
// plus hand-written sequences for saturation (8-bit instance) and mid-job reset.
module tb_popcount_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start, in_valid, in_ready, out_valid, out_ready, out_err, busy;
    logic [7:0]  len;
    logic [11:0] in_cnt;
    logic [15:0] out_sum;

    logic        start8, in_valid8, in_ready8, out_valid8, out_ready8, out_err8, busy8;
    logic [7:0]  len8;
    logic [11:0] in_cnt8;
    logic [7:0]  out_sum8;

    int checks = 0;
    int errors = 0;
    int cur    = 0;

    popcount_accumulator #(.LANES(4), .ACC_W(16), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_cnt(in_cnt),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_err(out_err), .busy(busy)
    );

    popcount_accumulator #(.LANES(4), .ACC_W(8), .LEN_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .len(len8),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_cnt(in_cnt8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_sum(out_sum8),
        .out_err(out_err8), .busy(busy8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]        len;
        logic [3:0][11:0]  beats;
        logic [3:0][1:0]   gaps;
        int                hold;
        logic [15:0]       exp_sum;
        logic              exp_err;
    } job_t;

    job_t jobs[10];

    function automatic logic [11:0] mk(input int a, input int b, input int c, input int d);
        logic [2:0] la, lb, lc, ld;
        la = a[2:0]; lb = b[2:0]; lc = c[2:0]; ld = d[2:0];
        return {ld, lc, lb, la};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s job %0d actual=%0d required=%0d", name, cur, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_job(input int idx, input int l,
                           input logic [11:0] b0, input logic [11:0] b1,
                           input logic [11:0] b2, input logic [11:0] b3,
                           input int g1, input int g2, input int g3, input int hold,
                           input int sum, input int err);
        jobs[idx].len     = l[7:0];
        jobs[idx].beats   = {b3, b2, b1, b0};
        jobs[idx].gaps    = {g3[1:0], g2[1:0], g1[1:0], 2'd0};
        jobs[idx].hold    = hold;
        jobs[idx].exp_sum = sum[15:0];
        jobs[idx].exp_err = err[0];
    endtask

    task automatic run_job(input job_t j);
        int rdy_cnt;
        int exp_rdy;
        rdy_cnt = 0;
        exp_rdy = 0;
        start = 1'b1; len = j.len; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        start = 1'b0; len = 8'hFF;
        if (j.len == 8'd0) chk("zero_len_valid", 32'(out_valid), 32'd1);
        else               chk("start_busy", 32'(busy), 32'd1);
        for (int b = 0; b < int'(j.len); b++) begin
            for (int g = 0; g < int'(j.gaps[b]); g++) begin
                in_valid = 1'b0; in_cnt = 12'hFFF;
                if (in_ready) rdy_cnt++;
                exp_rdy++;
                tick();
            end
            in_valid = 1'b1; in_cnt = j.beats[b];
            if (in_ready) rdy_cnt++;
            exp_rdy++;
            tick();
        end
        in_valid = 1'b0; in_cnt = 12'h000;
        chk("in_ready_cycles", 32'(rdy_cnt), 32'(exp_rdy));
        chk("done_valid", 32'(out_valid), 32'd1);
        chk("done_sum", 32'(out_sum), 32'(j.exp_sum));
        chk("done_err", 32'(out_err), 32'(j.exp_err));
        chk("done_in_ready", 32'(in_ready), 32'd0);
        for (int h = 0; h < j.hold; h++) begin
            start = h[0]; len = 8'd1;
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_sum", 32'(out_sum), 32'(j.exp_sum));
            chk("hold_err", 32'(out_err), 32'(j.exp_err));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        start = 1'b1; len = 8'd1; out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd0);
        chk("post_sum_kept", 32'(out_sum), 32'(j.exp_sum));
    endtask

    task automatic run8(input int l, input logic [11:0] body, input logic [11:0] last,
                        input int sum, input int err);
        start8 = 1'b1; len8 = l[7:0];
        tick();
        start8 = 1'b0;
        for (int b = 0; b < l; b++) begin
            in_valid8 = 1'b1;
            in_cnt8   = (b == l - 1) ? last : body;
            tick();
        end
        in_valid8 = 1'b0;
        chk("sat_valid", 32'(out_valid8), 32'd1);
        chk("sat_sum", 32'(out_sum8), 32'(sum));
        chk("sat_err", 32'(out_err8), 32'(err));
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        chk("sat_post_valid", 32'(out_valid8), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        set_job(0, 3, mk(5,5,5,5), mk(0,1,2,3), mk(4,4,4,4), 12'h0, 0, 0, 0, 0, 42, 0);
        set_job(1, 3, mk(5,5,5,5), mk(0,1,2,3), mk(4,4,4,4), 12'h0, 2, 1, 0, 0, 42, 0);
        set_job(2, 3, mk(5,5,5,5), mk(0,1,2,3), mk(4,4,4,4), 12'h0, 0, 0, 0, 5, 42, 0);
        set_job(3, 0, 12'h0, 12'h0, 12'h0, 12'h0, 0, 0, 0, 1, 0, 0);
        set_job(4, 1, mk(7,0,0,0), 12'h0, 12'h0, 12'h0, 0, 0, 0, 0, 7, 1);
        set_job(5, 1, mk(1,1,1,1), 12'h0, 12'h0, 12'h0, 0, 0, 0, 0, 4, 0);
        set_job(6, 2, mk(6,0,0,0), mk(0,0,0,0), 12'h0, 12'h0, 0, 0, 0, 0, 6, 1);
        set_job(7, 4, mk(5,5,5,5), mk(5,5,5,5), mk(5,5,5,5), mk(5,5,5,5), 1, 1, 1, 2, 80, 0);
        set_job(8, 2, mk(3,3,3,3), mk(2,2,2,2), 12'h0, 12'h0, 0, 3, 0, 0, 20, 0);
        set_job(9, 1, mk(2,2,2,2), 12'h0, 12'h0, 12'h0, 0, 0, 0, 0, 8, 0);

        rst_n = 1'b0;
        start = 1'b0; len = 8'd0; in_valid = 1'b0; in_cnt = 12'h0; out_ready = 1'b0;
        start8 = 1'b0; len8 = 8'd0; in_valid8 = 1'b0; in_cnt8 = 12'h0; out_ready8 = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", 32'(in_ready), 32'd0);

        for (int k = 0; k < 9; k++) begin
            cur = k;
            run_job(jobs[k]);
        end

        cur = 20;
        run8(12, mk(5,5,5,5), mk(5,5,5,5), 240, 0);
        cur = 21;
        run8(13, mk(5,5,5,5), mk(5,5,5,0), 255, 0);
        cur = 22;
        run8(20, mk(5,5,5,5), mk(5,5,5,5), 255, 1);

        cur = 30;
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_cnt = mk(5,5,5,5);
        tick();
        in_cnt = mk(7,0,0,0);
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_sum", 32'(out_sum), 32'd0);
        chk("midrst_out_err", 32'(out_err), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        cur = 9;
        run_job(jobs[9]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/popcount_accumulator.md
Name: popcount_accumulator

Overview:
- Receiving end of the 5-to-3 compressor stage.
- Each beat carries LANES compressed 3-bit partial counts, encoded {cout, carry, sum} with weights 4/2/1, legal range 0..5. These come from the XNOR-popcount front end.
- The block sums every lane of a beat, accumulates over a programmed number of beats, and returns one total through a valid/ready result port to the activation/threshold stage.

Parameters:
- LANES, 4, number of 3-bit compressed counts per input beat.
- ACC_W, 16, accumulator and result width in bits.
- LEN_W, 8, width of the beat-count field.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a new accumulation; sampled only in IDLE.
- len  input  LEN_W  number of input beats to accumulate; captured with start.
- in_valid  input  1  in_cnt holds a beat.
- in_ready  output  1  block accepts a beat this cycle.
- in_cnt  input  3*LANES  lane i in bits [3i+2:3i], MSB = cout (weight 4), LSB = sum (weight 1).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_sum  output  ACC_W  accumulated population count.
- out_err  output  1  illegal lane code seen or accumulator saturated; valid with out_valid.
- busy  output  1  high in ACCUM and DONE.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-low, rst_n. Reset is sampled on the clk edge.
- Reset values: state=IDLE, in_ready=0, out_valid=0, out_sum=0, out_err=0, busy=0, remaining-beat counter=0.
- Reset mid-operation aborts immediately. Any partial sum and any pending result are discarded, with no output handshake.
- State IDLE:
  - in_ready=0, out_valid=0.
  - start=1 with len≠0: capture len into the counter, clear the accumulator and err, go to ACCUM.
  - start=1 with len=0: clear the accumulator and err, go directly to DONE; the result is 0 with err=0.
- State ACCUM:
  - in_ready=1 (combinational from state only; not dependent on in_valid).
  - Beat accepted on in_valid & in_ready.
  - beat_sum = sum of all LANES 3-bit lane values. Width is clog2(7*LANES+1); for LANES=4 that is 5 bits.
  - acc_next = acc + beat_sum, saturating at 2^ACC_W−1. On saturation, set err (sticky).
  - Any lane value of 6 or 7 sets err (sticky). That lane is still added as its binary value.
  - On each accepted beat the counter decrements. When the counter is 1 on acceptance, go to DONE next cycle.
  - in_valid=0 holds state; there is no timeout.
  - start is ignored in ACCUM.
- State DONE:
  - out_valid=1, in_ready=0. out_sum = acc and out_err = err, both stable while out_valid=1 and out_ready=0.
  - out_valid & out_ready → IDLE next cycle; out_valid drops that cycle.
  - start in DONE is ignored, even in the cycle of the out handshake. A new start is accepted from IDLE at the earliest one cycle later.
- Latency: out_valid asserts on the cycle after the last beat is accepted. The zero-length case asserts the cycle after start.
- Throughput: one beat per cycle in ACCUM. Per job, the overhead is 1 cycle start→ACCUM, 1 cycle last beat→DONE, and ≥1 cycle DONE→IDLE.
- out_sum keeps its last value after the handshake until the next start clears the accumulator. Consumers use it only while out_valid=1.
- All arithmetic is unsigned.

Test Plan:
- LANES=4, ACC_W=16. start, len=3. Beats with lane values {5,5,5,5}, {0,1,2,3}, {4,4,4,4}, in_valid held high → in_ready high for exactly 3 cycles. out_valid on the cycle after the 3rd beat with out_sum=42, out_err=0.
- Same job with in_valid toggled 1,0,0,1,0,1 → identical result 42. The counter advances only on handshake cycles.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_valid, out_sum and out_err stable throughout. in_ready=0, and start pulses are ignored. Then out_ready=1 → IDLE next cycle.
- start, len=0 → out_valid the next cycle with out_sum=0, out_err=0, and no in_ready pulse.
- Illegal code: one beat with lane code 3'b111 and the other lanes 0, len=1 → out_sum=7, out_err=1. Then a following clean job with len=1 and all lanes 1 → out_sum=4, out_err=0 (err cleared by start).
- Saturation with ACC_W=8: len=20, all lanes 5 (20/beat) → out_sum=255, out_err=1.
- rst_n low for 1 cycle after 2 of 3 beats → all outputs return to reset values. A new start with len=1 and all lanes 2 → out_sum=8.
